// File: rtl/instr_fetch_mem_if.sv
// Fetch/load bus between a core (master) and the instruction memory (slave).
interface instr_fetch_mem_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] PC;
  logic [31:0]         INSTRUCTION;
  logic                BUSY;
  logic                VALID;
  logic                FAULT;
  logic                WR_EN;
  logic [PC_WIDTH-1:0] WR_ADDR;
  logic [7:0]          WR_DATA;

  modport master (
    output PC, WR_EN, WR_ADDR, WR_DATA,
    input  INSTRUCTION, BUSY, VALID, FAULT
  );

  modport slave (
    input  PC, WR_EN, WR_ADDR, WR_DATA,
    output INSTRUCTION, BUSY, VALID, FAULT
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed little-endian instruction store with a fixed-latency fetch
// engine that tracks the core PC and flags misaligned/out-of-range fetches.
module instr_fetch_mem #(
  parameter int          PC_WIDTH    = 32,
  parameter int          DEPTH_BYTES = 1024,
  parameter int          LATENCY     = 2,
  parameter int          ALIGN_CHECK = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input logic               CLK,
  input logic               RESET,
  instr_fetch_mem_if.slave  bus
);

  localparam int                ADDR_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [PC_WIDTH:0] DEPTH_EXT = (PC_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [2:0]        CNT_INIT  = 3'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [7:0]          mem [DEPTH_BYTES];
  state_t              state;
  logic                first;
  logic [PC_WIDTH-1:0] last_pc;
  logic [PC_WIDTH-1:0] cap_pc;
  logic [2:0]          cnt;

  logic [ADDR_W-1:0]   base;
  logic [31:0]         rd_word;
  logic                misaligned;
  logic                out_of_range;
  logic                fetch_fault;

  // Range check is widened by one bit so cap_pc near the top of the PC space cannot wrap.
  always_comb begin
    base         = cap_pc[ADDR_W-1:0];
    rd_word      = {mem[base + ADDR_W'(3)], mem[base + ADDR_W'(2)],
                    mem[base + ADDR_W'(1)], mem[base]};
    misaligned   = (ALIGN_CHECK != 0) && (cap_pc[1:0] != 2'b00);
    out_of_range = ({1'b0, cap_pc} + (PC_WIDTH+1)'(3)) >= DEPTH_EXT;
    fetch_fault  = misaligned || out_of_range;
  end

  // Memory is never cleared and keeps accepting writes through reset.
  always_ff @(posedge CLK) begin
    if (bus.WR_EN && ({1'b0, bus.WR_ADDR} < DEPTH_EXT)) begin
      mem[bus.WR_ADDR[ADDR_W-1:0]] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      first           <= 1'b1;
      last_pc         <= '0;
      cap_pc          <= '0;
      cnt             <= '0;
      bus.INSTRUCTION <= '0;
      bus.BUSY        <= 1'b0;
      bus.VALID       <= 1'b0;
      bus.FAULT       <= 1'b0;
    end else begin
      bus.VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (first || (bus.PC != last_pc)) begin
            cap_pc   <= bus.PC;
            last_pc  <= bus.PC;
            first    <= 1'b0;
            cnt      <= CNT_INIT;
            bus.BUSY <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.PC != cap_pc) begin
            cap_pc  <= bus.PC;
            last_pc <= bus.PC;
            cnt     <= CNT_INIT;
          end else if (cnt == 3'd0) begin
            bus.BUSY  <= 1'b0;
            bus.VALID <= 1'b1;
            state     <= IDLE;
            if (fetch_fault) begin
              bus.INSTRUCTION <= NOP_WORD;
              bus.FAULT       <= 1'b1;
            end else begin
              bus.INSTRUCTION <= rd_word;
              bus.FAULT       <= 1'b0;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench: two fetch engines (latency 2 and 3) sharing a load port,
// table-driven fetches plus hand-built restart, write-race and reset sequences.
module tb_instr_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] pc2, pc3;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;

  int   errors = 0;
  int   checks = 0;
  logic sticky = 1'b0;
  exp_t q2[$];
  exp_t q3[$];

  instr_fetch_mem_if #(.PC_WIDTH(32)) bus2 ();
  instr_fetch_mem_if #(.PC_WIDTH(32)) bus3 ();

  assign bus2.PC      = pc2;
  assign bus2.WR_EN   = wr_en;
  assign bus2.WR_ADDR = wr_addr;
  assign bus2.WR_DATA = wr_data;
  assign bus3.PC      = pc3;
  assign bus3.WR_EN   = wr_en;
  assign bus3.WR_ADDR = wr_addr;
  assign bus3.WR_DATA = wr_data;

  instr_fetch_mem #(.PC_WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(2),
                    .ALIGN_CHECK(1), .NOP_WORD(NOP)) u2 (
    .CLK(CLK), .RESET(RESET), .bus(bus2));

  instr_fetch_mem #(.PC_WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(3),
                    .ALIGN_CHECK(1), .NOP_WORD(32'h0)) u3 (
    .CLK(CLK), .RESET(RESET), .bus(bus3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every VALID pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus2.VALID) begin
      chk("u2_valid_and_busy", {31'b0, bus2.BUSY}, 32'd0);
      if (q2.size() == 0) chk("u2_unexpected_valid", {31'b0, bus2.VALID}, 32'd0);
      else begin
        exp_t e2;
        e2 = q2.pop_front();
        chk("u2_instr", bus2.INSTRUCTION, e2.instr);
        chk("u2_fault", {31'b0, bus2.FAULT}, {31'b0, e2.fault});
      end
    end
    if (bus3.VALID) begin
      if (q3.size() == 0) chk("u3_unexpected_valid", {31'b0, bus3.VALID}, 32'd0);
      else begin
        exp_t e3;
        e3 = q3.pop_front();
        chk("u3_instr", bus3.INSTRUCTION, e3.instr);
        chk("u3_fault", {31'b0, bus3.FAULT}, {31'b0, e3.fault});
      end
    end
  end

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) begin
      logic [31:0] wv;
      wv = w >> (8 * i);
      wr_byte(a + i, wv[7:0]);
    end
  endtask

  // Called at the negedge where the fetch was launched; returns at the VALID negedge.
  task automatic wait_v2(input string tag);
    int n = 0;
    int nb = 0;
    do begin
      @(negedge CLK);
      n++;
      if (bus2.BUSY) begin
        nb++;
        if (nb == 1) chk({tag, "_sticky_fault"}, {31'b0, bus2.FAULT}, {31'b0, sticky});
      end
    end while (!bus2.VALID && n < 20);
    chk({tag, "_latency"}, n, 32'd3);
    chk({tag, "_busy_cycles"}, nb, 32'd2);
  endtask

  task automatic fetch2(input string tag, input logic [31:0] a,
                        input logic [31:0] ei, input logic ef);
    q2.push_back('{instr: ei, fault: ef});
    pc2 = a;
    wait_v2(tag);
    sticky = ef;
  endtask

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{pc: 32'd4,    instr: 32'h0104_0003, fault: 1'b0};
    tbl[1] = '{pc: 32'd8,    instr: 32'h0003_0002, fault: 1'b0};
    tbl[2] = '{pc: 32'd2,    instr: NOP,           fault: 1'b1};
    tbl[3] = '{pc: 32'd1020, instr: 32'hCAFE_F00D, fault: 1'b0};
    tbl[4] = '{pc: 32'd1021, instr: NOP,           fault: 1'b1};
    tbl[5] = '{pc: 32'd0,    instr: 32'h0003_0006, fault: 1'b0};
    tbl[6] = '{pc: 32'd12,   instr: 32'h1234_5678, fault: 1'b0};

    RESET = 1'b1; pc2 = '0; pc3 = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge CLK);
    chk("rst_instr", bus2.INSTRUCTION, 32'd0);
    chk("rst_busy",  {31'b0, bus2.BUSY},  32'd0);
    chk("rst_valid", {31'b0, bus2.VALID}, 32'd0);
    chk("rst_fault", {31'b0, bus2.FAULT}, 32'd0);

    // Program memory while still in reset; the 1024 write must not alias byte 0.
    wr_word(32'd0,    32'h0003_0006);
    wr_word(32'd4,    32'h0104_0003);
    wr_word(32'd8,    32'h0003_0002);
    wr_word(32'd12,   32'h1234_5678);
    wr_word(32'd16,   32'h4433_2211);
    wr_word(32'd1020, 32'hCAFE_F00D);
    wr_byte(32'd1024, 8'hEE);

    q2.push_back('{instr: 32'h0003_0006, fault: 1'b0});
    q3.push_back('{instr: 32'h0003_0006, fault: 1'b0});
    RESET = 1'b0;
    wait_v2("first_fetch");

    for (int unsigned i = 0; i < 7; i++) begin
      fetch2($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].fault);
    end

    // Restart on the latency-3 engine: PC 4 abandoned one cycle in, 12 completes.
    @(negedge CLK);
    pc3 = 32'd4;
    @(negedge CLK);
    chk("u3_busy", {31'b0, bus3.BUSY}, 32'd1);
    q3.push_back('{instr: 32'h1234_5678, fault: 1'b0});
    pc3 = 32'd12;
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus3.VALID && n < 20);
    chk("u3_restart_latency", n, 32'd4);

    // Write one edge before completion is visible.
    q2.push_back('{instr: 32'h4433_22AA, fault: 1'b0});
    pc2 = 32'd16;
    @(negedge CLK);
    wr_byte(32'd16, 8'hAA);
    @(negedge CLK);
    chk("wr_early_valid", {31'b0, bus2.VALID}, 32'd1);
    sticky = 1'b0;
    fetch2("back_to_0", 32'd0, 32'h0003_0006, 1'b0);

    // Write on the completion edge returns the old byte.
    q2.push_back('{instr: 32'h4433_22AA, fault: 1'b0});
    pc2 = 32'd16;
    @(negedge CLK);
    @(negedge CLK);
    wr_byte(32'd16, 8'hBB);
    chk("wr_same_edge_valid", {31'b0, bus2.VALID}, 32'd1);
    fetch2("back_to_0b", 32'd0, 32'h0003_0006, 1'b0);
    fetch2("reread_16", 32'd16, 32'h4433_22BB, 1'b0);
    fetch2("fault_pre_rst", 32'd2, NOP, 1'b1);

    // Reset mid-fetch of PC 8.
    pc2 = 32'd8;
    @(negedge CLK);
    chk("mid_busy", {31'b0, bus2.BUSY}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_instr", bus2.INSTRUCTION, 32'd0);
    chk("mid_rst_busy",  {31'b0, bus2.BUSY},  32'd0);
    chk("mid_rst_valid", {31'b0, bus2.VALID}, 32'd0);
    chk("mid_rst_fault", {31'b0, bus2.FAULT}, 32'd0);
    q2.push_back('{instr: 32'h0003_0002, fault: 1'b0});
    q3.push_back('{instr: 32'h1234_5678, fault: 1'b0});
    sticky = 1'b0;
    RESET = 1'b0;
    wait_v2("post_rst");

    repeat (10) @(negedge CLK);
    chk("q2_drained", q2.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Byte-addressed, little-endian instruction memory with a timed fetch engine for the 8-bit processor family. It replaces the behavioural instruction store used in processor benches with synthesizable RTL. The block watches the core's PC, fetches a 32-bit instruction after a configurable latency, and reports busy, valid and fault status so the core can stall. A byte-wide load port programs the memory.

Parameters:
PC_WIDTH, 32, width of PC and load address
DEPTH_BYTES, 1024, memory size in bytes; must be a multiple of 4
LATENCY, 2, cycles from PC capture to instruction update; legal range 1..8
ALIGN_CHECK, 1, 1 = PC[1:0] != 0 is a fault; 0 = unaligned fetch allowed (bytes PC..PC+3)
NOP_WORD, 32'h0000_0000, value driven on INSTRUCTION after a faulting fetch

Ports:
CLK  in  1  clock; all state changes on the rising edge
RESET  in  1  synchronous, active-high reset
PC  in  PC_WIDTH  fetch address from the core
INSTRUCTION  out  32  {mem[a+3], mem[a+2], mem[a+1], mem[a]}, registered
BUSY  out  1  fetch in progress; the core must hold PC stable or accept a restart
VALID  out  1  one-cycle pulse after INSTRUCTION updates
FAULT  out  1  last completed fetch was misaligned or out of range
WR_EN  in  1  byte write strobe
WR_ADDR  in  PC_WIDTH  byte write address
WR_DATA  in  8  byte write data

Behaviour:
- Reset (RESET high at an edge): INSTRUCTION = 0, VALID = 0, BUSY = 0, FAULT = 0, state = IDLE, `first` flag = 1, last_pc = 0. Memory contents are not cleared. Writes with WR_EN high during reset are still performed.
- States:
  - IDLE: at an edge where (first == 1 or PC != last_pc) and RESET is low, set cap_pc = PC, last_pc = PC, first = 0, cnt = LATENCY-1, go to WAIT.
  - WAIT: BUSY = 1.
    - If PC != cap_pc at an edge, restart: cap_pc = PC, last_pc = PC, cnt = LATENCY-1, stay in WAIT. No VALID pulse is produced for the aborted fetch.
    - Otherwise, if cnt == 0, complete the fetch: load INSTRUCTION, set VALID = 1 for the next cycle, update FAULT, go to IDLE.
    - Otherwise, decrement cnt.
- Latency: the PC is sampled at edge k. INSTRUCTION and VALID change at edge k+LATENCY. BUSY is high during cycles k..k+LATENCY-1 (after edge k through edge k+LATENCY).
  - LATENCY=1 completes at the next edge.
  - A new PC seen in the same cycle VALID is high starts a new fetch at that edge; IDLE lasts zero extra cycles.
- Fault is evaluated at completion on cap_pc:
  - Misaligned: ALIGN_CHECK=1 and cap_pc[1:0] != 0.
  - Out of range: cap_pc + 3 >= DEPTH_BYTES. Compute in PC_WIDTH+1 bits so no wrap.
  - On a fault: INSTRUCTION = NOP_WORD and FAULT = 1.
  - FAULT is sticky until the next non-faulting completion or reset.
- Memory read at completion uses contents before that edge's write (read-before-write). A write landing at an earlier edge of the same fetch is visible.
- Writes with WR_ADDR >= DEPTH_BYTES are ignored silently. Writes never alter BUSY, VALID or FAULT.
- Reset mid-fetch aborts the fetch with no VALID. After reset releases, `first` = 1 forces a fetch of the current PC even if it is 0.
- VALID and BUSY are never both high.

Test Plan:
- Load words 0x0003_0006 at byte 0 and 0x0104_0003 at byte 4, release reset with PC=0, LATENCY=2 -> BUSY high for 2 cycles, then INSTRUCTION=0x0003_0006 and a single VALID pulse. Mem[0]=0x06, mem[3]=0x00 confirms little-endian order.
- Step PC 0 -> 4 -> 8 at each VALID, with byte 8 loaded with 0x0003_0002 -> INSTRUCTION sequence 0x0003_0006, 0x0104_0003, 0x0003_0002. Each arrives exactly LATENCY edges after its PC change.
- Change PC from 4 to 12 one cycle into a LATENCY=3 fetch -> no VALID for PC=4; INSTRUCTION equals the word at 12, 3 edges after the change.
- PC=2 with ALIGN_CHECK=1 -> FAULT=1 and INSTRUCTION=NOP_WORD. Then PC=1020 with DEPTH_BYTES=1024 -> no fault. PC=1021 -> FAULT=1. Then PC=0 -> FAULT clears.
- During a fetch of PC=16, write byte 16=0xAA one edge before completion -> INSTRUCTION[7:0]=0xAA. Write the same byte at the completion edge -> old byte returned.
- Assert RESET for 1 cycle mid-fetch with PC held at 8 -> no VALID for the aborted fetch, all outputs 0, then a fresh fetch of PC=8 completes LATENCY edges after reset deasserts.
